// File: rtl/fp_square_iter.sv
// Iterative floating-point squarer: sqrt-format operand (Q1.11, signed exponent) in, square in Q1.7 out.
// Optional build macro SQUARE_ROUND_EN: round-to-nearest-even via an extra RND state (else truncate).
module fp_square_iter #(
    parameter int FW_I = 12,
    parameter int FW_O = 8,
    parameter int EW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            doSquare_i,
    input  logic            s_i,
    input  logic [FW_I-1:0] f_i,
    input  logic [EW-1:0]   e_i,
    input  logic            isZ_i,
    input  logic            isInf_i,
    input  logic            isSNAN_i,
    input  logic            isQNAN_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic            s_o,
    output logic [FW_O-1:0] f_o,
    output logic [EW-1:0]   e_o,
    output logic            isOverflow_o,
    output logic            isUnderflow_o,
    output logic            isToRound_o,
    output logic            isZ_o,
    output logic            isInf_o,
    output logic            isNAN_o
);
    // state | meaning
    // IDLE  | waiting for doSquare_i
    // MUL   | shift-add, one multiplier bit per cycle
    // NORM  | pick mantissa window, form exponent
    // RND   | round-to-nearest-even (SQUARE_ROUND_EN only)
    // SPEC  | resolve special-operand precedence
    // DONE  | drive result registers and valid strobe
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_NORM, S_RND, S_SPEC, S_DONE} state_t;

    localparam int PW = 2 * FW_I;
    localparam int CW = $clog2(FW_I);
    localparam int XW = EW + 2;
    localparam int LO = PW - FW_O;
    localparam logic signed [XW-1:0] EXP_MAX = XW'((2 ** (EW - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_MIN = XW'(-(2 ** (EW - 1)));
    localparam logic [EW-1:0]   E_MAX  = {1'b0, {(EW-1){1'b1}}};
    localparam logic [EW-1:0]   E_MIN  = {1'b1, {(EW-1){1'b0}}};
    localparam logic [FW_O-1:0] F_ONE  = {1'b1, {(FW_O-1){1'b0}}};
    localparam logic [FW_O-1:0] F_NAN  = {2'b11, {(FW_O-2){1'b0}}};
    localparam logic [1:0] K_NORM = 2'd0, K_ZERO = 2'd1, K_INF = 2'd2, K_NAN = 2'd3;

    state_t state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW_I-1:0] mcand_q, mcand_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [EW-1:0]   e_q, e_d;
    logic            s_q, s_d;
    logic            sn_q, sn_d, qn_q, qn_d, inf_q, inf_d, z_q, z_d;
    logic [1:0]      kind_q, kind_d;
    logic [FW_O-1:0] res_f_q, res_f_d;
    logic signed [XW-1:0] res_exp_q, res_exp_d;
    logic            inx_q, inx_d;

    logic            valid_q, valid_d, so_q, so_d;
    logic [FW_O-1:0] fo_q, fo_d;
    logic [EW-1:0]   eo_q, eo_d;
    logic            ovf_q, ovf_d, unf_q, unf_d, rnd_q, rnd_d;
    logic            zo_q, zo_d, info_q, info_d, nano_q, nano_d;

    logic [FW_I:0]   sum;
    logic            hi;
    logic [FW_O-1:0] norm_f;
    logic            norm_inx;
    logic signed [XW-1:0] norm_exp;
`ifdef SQUARE_ROUND_EN
    logic            rup_q, rup_d;
    logic            guard, sticky;
    logic [FW_O:0]   f_inc;
`endif

    always_comb begin
        sum      = {1'b0, prod_q[PW-1:FW_I]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        hi       = prod_q[PW-1];
        norm_f   = hi ? prod_q[PW-1 -: FW_O] : prod_q[PW-2 -: FW_O];
        norm_inx = hi ? |prod_q[LO-1:0] : |prod_q[LO-2:0];
        // Squaring doubles the exponent; a product in [2,4) contributes one more.
        norm_exp = {e_q[EW-1], e_q, 1'b0} + XW'(hi);
`ifdef SQUARE_ROUND_EN
        guard    = hi ? prod_q[LO-1] : prod_q[LO-2];
        sticky   = hi ? |prod_q[LO-2:0] : |prod_q[LO-3:0];
        f_inc    = {1'b0, res_f_q} + (FW_O+1)'(rup_q);
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        e_d       = e_q;
        s_d       = s_q;
        sn_d      = sn_q;
        qn_d      = qn_q;
        inf_d     = inf_q;
        z_d       = z_q;
        kind_d    = kind_q;
        res_f_d   = res_f_q;
        res_exp_d = res_exp_q;
        inx_d     = inx_q;
        valid_d   = 1'b0;
        so_d      = so_q;
        fo_d      = fo_q;
        eo_d      = eo_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        rnd_d     = rnd_q;
        zo_d      = zo_q;
        info_d    = info_q;
        nano_d    = nano_q;
`ifdef SQUARE_ROUND_EN
        rup_d     = rup_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (doSquare_i) begin
                    s_d     = s_i;
                    e_d     = e_i;
                    sn_d    = isSNAN_i;
                    qn_d    = isQNAN_i;
                    inf_d   = isInf_i;
                    z_d     = isZ_i;
                    mcand_d = f_i;
                    prod_d  = {{FW_I{1'b0}}, f_i};
                    cnt_d   = CW'(FW_I - 1);
                    kind_d  = K_NORM;
                    if (isSNAN_i || isQNAN_i || isInf_i || isZ_i) state_d = S_SPEC;
                    else                                           state_d = S_MUL;
                end
            end
            S_MUL: begin
                // Multiplier sits in the low half and shifts out as the sum shifts in.
                prod_d = {sum, prod_q[FW_I-1:1]};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_NORM;
            end
            S_NORM: begin
                res_f_d   = norm_f;
                res_exp_d = norm_exp;
                inx_d     = norm_inx;
`ifdef SQUARE_ROUND_EN
                rup_d     = guard & (sticky | norm_f[0]);
                state_d   = S_RND;
`else
                state_d   = S_DONE;
`endif
            end
`ifdef SQUARE_ROUND_EN
            S_RND: begin
                if (f_inc[FW_O]) begin
                    res_f_d   = F_ONE;
                    res_exp_d = res_exp_q + XW'(1);
                end else begin
                    res_f_d   = f_inc[FW_O-1:0];
                end
                state_d = S_DONE;
            end
`endif
            S_SPEC: begin
                if (sn_q || qn_q) kind_d = K_NAN;
                else if (inf_q)   kind_d = K_INF;
                else              kind_d = K_ZERO;
                state_d = S_DONE;
            end
            S_DONE: begin
                valid_d = 1'b1;
                so_d    = 1'b0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                rnd_d   = 1'b0;
                zo_d    = 1'b0;
                info_d  = 1'b0;
                nano_d  = 1'b0;
                case (kind_q)
                    K_NAN:  begin nano_d = 1'b1; so_d = s_q; fo_d = F_NAN; eo_d = E_MAX; end
                    K_INF:  begin info_d = 1'b1; fo_d = F_ONE; eo_d = E_MAX; end
                    K_ZERO: begin zo_d = 1'b1; fo_d = '0; eo_d = '0; end
                    default: begin
                        rnd_d = inx_q;
                        if (res_exp_q > EXP_MAX) begin
                            ovf_d = 1'b1; fo_d = '1; eo_d = E_MAX;
                        end else if (res_exp_q < EXP_MIN) begin
                            unf_d = 1'b1; fo_d = F_ONE; eo_d = E_MIN;
                        end else begin
                            fo_d = res_f_q; eo_d = res_exp_q[EW-1:0];
                        end
                    end
                endcase
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            e_q       <= '0;
            s_q       <= 1'b0;
            sn_q      <= 1'b0;
            qn_q      <= 1'b0;
            inf_q     <= 1'b0;
            z_q       <= 1'b0;
            kind_q    <= K_NORM;
            res_f_q   <= '0;
            res_exp_q <= '0;
            inx_q     <= 1'b0;
            valid_q   <= 1'b0;
            so_q      <= 1'b0;
            fo_q      <= '0;
            eo_q      <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            rnd_q     <= 1'b0;
            zo_q      <= 1'b0;
            info_q    <= 1'b0;
            nano_q    <= 1'b0;
`ifdef SQUARE_ROUND_EN
            rup_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            e_q       <= e_d;
            s_q       <= s_d;
            sn_q      <= sn_d;
            qn_q      <= qn_d;
            inf_q     <= inf_d;
            z_q       <= z_d;
            kind_q    <= kind_d;
            res_f_q   <= res_f_d;
            res_exp_q <= res_exp_d;
            inx_q     <= inx_d;
            valid_q   <= valid_d;
            so_q      <= so_d;
            fo_q      <= fo_d;
            eo_q      <= eo_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            rnd_q     <= rnd_d;
            zo_q      <= zo_d;
            info_q    <= info_d;
            nano_q    <= nano_d;
`ifdef SQUARE_ROUND_EN
            rup_q     <= rup_d;
`endif
        end
    end

    // The strobe cycle is already IDLE (a new operand may be accepted) but still reports busy.
    assign busy_o        = (state_q != S_IDLE) || valid_q;
    assign valid_o       = valid_q;
    assign s_o           = so_q;
    assign f_o           = fo_q;
    assign e_o           = eo_q;
    assign isOverflow_o  = ovf_q;
    assign isUnderflow_o = unf_q;
    assign isToRound_o   = rnd_q;
    assign isZ_o         = zo_q;
    assign isInf_o       = info_q;
    assign isNAN_o       = nano_q;

endmodule

// File: tb/tb_fp_square_iter.sv
// Self-checking bench for fp_square_iter: arithmetic reference model, queue scoreboard, random operands.
module tb_fp_square_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        doSquare_i = 1'b0, s_i = 1'b0;
    logic [11:0] f_i = '0;
    logic [7:0]  e_i = '0;
    logic        isZ_i = 1'b0, isInf_i = 1'b0, isSNAN_i = 1'b0, isQNAN_i = 1'b0;
    logic        busy_o, valid_o, s_o;
    logic [7:0]  f_o, e_o;
    logic        isOverflow_o, isUnderflow_o, isToRound_o, isZ_o, isInf_o, isNAN_o;

    fp_square_iter dut (
        .clk(clk), .rst(rst), .doSquare_i(doSquare_i), .s_i(s_i), .f_i(f_i), .e_i(e_i),
        .isZ_i(isZ_i), .isInf_i(isInf_i), .isSNAN_i(isSNAN_i), .isQNAN_i(isQNAN_i),
        .busy_o(busy_o), .valid_o(valid_o), .s_o(s_o), .f_o(f_o), .e_o(e_o),
        .isOverflow_o(isOverflow_o), .isUnderflow_o(isUnderflow_o), .isToRound_o(isToRound_o),
        .isZ_o(isZ_o), .isInf_o(isInf_o), .isNAN_o(isNAN_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       s;
        bit [7:0] f;
        bit [7:0] e;
        bit       ovf, unf, rnd, z, inf, nan;
        int       lat;
        int       cyc;
    } res_t;

    res_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic res_t model(input bit s, input int f, input int e,
                                   input bit sn, input bit qn, input bit inf, input bit z);
        res_t r;
        longint p, quo, rem, half;
        int sh, ex;
        r = '{default: 0};
        if (sn || qn) begin
            r.nan = 1; r.s = s; r.f = 8'hC0; r.e = 8'h7F; r.lat = 2;
        end else if (inf) begin
            r.inf = 1; r.f = 8'h80; r.e = 8'h7F; r.lat = 2;
        end else if (z) begin
            r.z = 1; r.f = 8'h00; r.e = 8'h00; r.lat = 2;
        end else begin
            p   = longint'(f) * longint'(f);
            sh  = (p >= 64'd8388608) ? 16 : 15;
            ex  = 2 * e + ((sh == 16) ? 1 : 0);
            quo = p >> sh;
            rem = p - (quo << sh);
            r.rnd = (rem != 0);
`ifdef SQUARE_ROUND_EN
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && quo[0])) quo++;
            if (quo == 256) begin quo = 128; ex++; end
            r.lat = 15;
`else
            half = 0;
            r.lat = 14;
`endif
            if (ex > 127) begin
                r.ovf = 1; r.e = 8'h7F; r.f = 8'hFF;
            end else if (ex < -128) begin
                r.unf = 1; r.e = 8'h80; r.f = 8'h80;
            end else begin
                r.f = quo[7:0]; r.e = ex[7:0];
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        res_t m;
        if (rst && valid_o) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                m = q.pop_front();
                chk("latency_cycle", cyc, m.cyc);
                chk("busy_at_valid", int'(busy_o), 1);
                chk("s_o", int'(s_o), int'(m.s));
                chk("f_o", int'(f_o), int'(m.f));
                chk("e_o", int'(e_o), int'(m.e));
                chk("flags", int'({isOverflow_o, isUnderflow_o, isToRound_o, isZ_o, isInf_o, isNAN_o}),
                    int'({m.ovf, m.unf, m.rnd, m.z, m.inf, m.nan}));
            end
        end
    end

    task automatic wait_idle();
        int i;
        for (i = 0; i < 200 && busy_o; i++) @(negedge clk);
        if (busy_o) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_valid();
        int i;
        for (i = 0; i < 200 && !valid_o; i++) @(negedge clk);
        if (!valid_o) chk("valid_timeout", 1, 0);
    endtask

    // Called at a negedge; the operand is accepted on the following posedge.
    task automatic issue(input bit s, input int f, input int e, input bit sn, input bit qn,
                         input bit inf, input bit z, input bit expect_res, input bit b2b);
        res_t m;
        if (!b2b) wait_idle();
        s_i = s; f_i = f[11:0]; e_i = e[7:0];
        isSNAN_i = sn; isQNAN_i = qn; isInf_i = inf; isZ_i = z;
        doSquare_i = 1'b1;
        if (expect_res) begin
            m = model(s, f, e, sn, qn, inf, z);
            m.cyc = cyc + 1 + m.lat;
            q.push_back(m);
        end
        @(negedge clk);
        doSquare_i = 1'b0;
        s_i = $urandom_range(0, 1); f_i = 12'($urandom); e_i = 8'($urandom);
        isSNAN_i = 1'b0; isQNAN_i = 1'b0; isInf_i = 1'b0; isZ_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, int'({busy_o, valid_o, s_o, f_o, e_o, isOverflow_o, isUnderflow_o,
                      isToRound_o, isZ_o, isInf_o, isNAN_o}), 0);
    endtask

    initial begin
        res_t m;
        int f, e, k;
        bit sn, qn, inf, z;

        m = model(0, 12'h800, 0, 0, 0, 0, 0);
        chk("pin1_f", int'(m.f), 8'h80); chk("pin1_e", int'(m.e), 0);
        chk("pin1_rnd", int'(m.rnd), 0); chk("pin1_lat", m.lat, 14);
        m = model(0, 12'hC00, 3, 0, 0, 0, 0);
        chk("pin2_f", int'(m.f), 8'h90); chk("pin2_e", int'(m.e), 7);
        m = model(0, 12'h800, 70, 0, 0, 0, 0);
        chk("pin3_ovf", int'({m.ovf, m.e}), 9'h17F);
        m = model(0, 12'h800, -65, 0, 0, 0, 0);
        chk("pin3_unf", int'({m.unf, m.e}), 9'h180);
        m = model(0, 12'hFFF, 0, 0, 0, 0, 0);
        chk("pin4_rnd", int'(m.rnd), 1);
`ifdef SQUARE_ROUND_EN
        chk("pin4_f", int'(m.f), 8'h80); chk("pin4_e", int'(m.e), 2); chk("pin4_lat", m.lat, 15);
`else
        chk("pin4_f", int'(m.f), 8'hFF); chk("pin4_e", int'(m.e), 1); chk("pin4_lat", m.lat, 14);
`endif
        m = model(1, 12'h800, 0, 1, 0, 1, 0);
        chk("pin5_nan", int'({m.nan, m.inf, m.s}), 3'b101); chk("pin5_lat", m.lat, 2);

        repeat (3) @(negedge clk);
        chk_all_zero("reset_outputs");
        rst = 1'b1;
        @(negedge clk);

        issue(0, 12'h800, 0, 0, 0, 0, 0, 1, 0);
        issue(0, 12'hC00, 3, 0, 0, 0, 0, 1, 0);
        issue(0, 12'h800, 70, 0, 0, 0, 0, 1, 0);
        issue(0, 12'h800, -65, 0, 0, 0, 0, 1, 0);
        issue(0, 12'hFFF, 0, 0, 0, 0, 0, 1, 0);
        issue(0, 12'hFFF, 63, 0, 0, 0, 0, 1, 0);
        issue(1, 12'h800, 0, 1, 0, 1, 0, 1, 0);
        doSquare_i = 1'b1; f_i = 12'h900;
        @(negedge clk);
        doSquare_i = 1'b0;
        issue(0, 12'hA55, -5, 0, 0, 0, 0, 1, 0);
        repeat (3) @(negedge clk);
        doSquare_i = 1'b1; f_i = 12'h800;
        @(negedge clk);
        doSquare_i = 1'b0;
        issue(1, 12'h800, 0, 0, 1, 1, 1, 1, 0);
        issue(1, 12'h800, 0, 0, 0, 1, 1, 1, 0);
        issue(1, 12'h800, 0, 0, 0, 0, 1, 1, 0);
        wait_valid();
        issue(0, 12'hB3C, 12, 0, 0, 0, 0, 1, 1);

        issue(0, 12'hDEF, 4, 0, 0, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("abort_outputs");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk_all_zero("post_abort_quiet");
        issue(0, 12'h800, 0, 0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 150; i++) begin
            f = int'($urandom_range(12'h800, 12'hFFF));
            k = int'($urandom_range(0, 9));
            e = (k == 0) ? 63 + int'($urandom_range(0, 1)) :
                (k == 1) ? -64 - int'($urandom_range(0, 1)) :
                int'($urandom_range(0, 255)) - 128;
            sn = 0; qn = 0; inf = 0; z = 0;
            if ($urandom_range(0, 7) == 0) begin
                sn = $urandom_range(0, 1); qn = $urandom_range(0, 1);
                inf = $urandom_range(0, 1); z = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) begin
                wait_valid();
                issue($urandom_range(0, 1), f, e, sn, qn, inf, z, 1, 1);
            end else begin
                issue($urandom_range(0, 1), f, e, sn, qn, inf, z, 1, 0);
            end
        end

        for (int i = 0; i < 500 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
